// File: rtl/store_pkg.sv
// Shared types for the MEM-stage store path: size encodings, drain FSM states
// and the store queue entry layout.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } st_size_e;

  typedef enum logic {
    IDLE,
    REQ
  } drain_state_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering: replicates narrow store data across byte lanes,
// builds byte enables and flags misaligned or reserved-size requests.
module store_lane_align
  import store_pkg::*;
(
  input  st_size_e    size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    wdata      = '0;
    be         = '0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        wdata      = {2{data[15:0]}};
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        wdata      = data;
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// MEM-stage store narrowing plus a small FIFO write buffer draining to data
// memory over req/ack, with a load-vs-pending-store hazard flag.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        misalign,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  st_entry_t        fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  drain_state_e     state_q, state_d;
  logic             misalign_q, misalign_d;
  logic             busy_q, busy_d;

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_misaligned;
  logic        accept, push, pop;
  st_entry_t   head, new_entry;
  logic [PTR_W-1:0] idx;

  store_lane_align u_align (
    .size       (st_size_e'(st_size)),
    .addr_lo    (st_addr[1:0]),
    .data       (st_data),
    .wdata      (al_wdata),
    .be         (al_be),
    .misaligned (al_misaligned)
  );

  assign st_ready  = (count_q != CNT_FULL);
  assign accept    = st_valid && st_ready;
  assign push      = accept && !al_misaligned;
  assign pop       = (state_q == REQ) && mem_ack;
  assign new_entry = '{waddr: st_addr[31:2], data: al_wdata, be: al_be};

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    state_d = state_q;
    case (state_q)
      IDLE: if (count_q != '0) state_d = REQ;
      REQ:  if (mem_ack && count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    misalign_d = accept && al_misaligned;
    // Registered so busy reflects the state and count that are current after the edge.
    busy_d     = (state_d != IDLE) || (count_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      misalign_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      misalign_q <= misalign_d;
      busy_q     <= busy_d;
    end
  end

  // NOTE: queue storage has no reset; validity comes solely from the pointers
  // and count, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_entry;
  end

  assign head      = fifo_q[rd_ptr_q];
  assign mem_req   = (state_q == REQ);
  assign mem_addr  = mem_req ? {head.waddr, 2'b00} : '0;
  assign mem_wdata = mem_req ? head.data : '0;
  assign mem_be    = mem_req ? head.be : '0;
  assign misalign  = misalign_q;
  assign busy      = busy_q;

  // Walk entries in queue order from the head; only the first count_q are live.
  always_comb begin
    ld_hazard = 1'b0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (((PTR_W+1)'(k) < count_q) && (fifo_q[idx].waddr == ld_addr[31:2]))
        ld_hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit (DEPTH=2): narrowing, misalign pulse,
// full queue back-pressure, load hazard, streaming drain and mid-handshake reset.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        busy;

  int checks = 0;
  int errors = 0;

  store_narrow_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .misalign(misalign),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one store for a single edge; returns 1ns after that edge.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_size = sz; st_addr = a; st_data = d;
    step();
    st_valid = 1'b0;
  endtask

  task automatic ack_once();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b exp 1", st_ready); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
    checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin errors++; $display("FAIL reset_mem_bus got %h %h %b exp 0", mem_addr, mem_wdata, mem_be); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_byte();
    do_store(2'b00, 32'h0000_1003, 32'hAABB_CC5A);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL byte_req_early got %b exp 0", mem_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL byte_busy got %b exp 1", busy); end
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL byte_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL byte_addr got %h exp 00001000", mem_addr); end
    checks++; if (mem_wdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL byte_wdata got %h exp 5a5a5a5a", mem_wdata); end
    checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL byte_be got %b exp 1000", mem_be); end
    ack_once();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL byte_req_after_ack got %b exp 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL byte_busy_after_ack got %b exp 0", busy); end
    do_store(2'b00, 32'h0000_1001, 32'h0000_0077);
    step();
    checks++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h7777_7777) begin errors++; $display("FAIL byte_lane1 got %b %h exp 0010 77777777", mem_be, mem_wdata); end
    ack_once();
  endtask

  task automatic test_half_misalign();
    do_store(2'b01, 32'h0000_2002, 32'h1234_BEEF);
    step();
    checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL half_wdata got %h exp beefbeef", mem_wdata); end
    checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL half_be got %b exp 1100", mem_be); end
    checks++; if (mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL half_addr got %h exp 00002000", mem_addr); end
    ack_once();
    do_store(2'b01, 32'h0000_2001, 32'h1234_BEEF);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL half_mis_pulse got %b exp 1", misalign); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL half_mis_busy got %b exp 0", busy); end
    step();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL half_mis_width got %b exp 0", misalign); end
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL half_mis_nowrite req %b busy %b exp 0 0", mem_req, busy); end
    do_store(2'b11, 32'h0000_2000, 32'h0);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL rsvd_pulse got %b exp 1", misalign); end
    do_store(2'b10, 32'h0000_2002, 32'h0);
    checks++; if (misalign !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL word_mis mis %b busy %b exp 1 0", misalign, busy); end
    step();
  endtask

  task automatic test_fill();
    do_store(2'b10, 32'h0000_5000, 32'h1111_1111);
    do_store(2'b10, 32'h0000_5004, 32'h2222_2222);
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", st_ready); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5000) begin errors++; $display("FAIL fill_head req %b addr %h exp 1 00005000", mem_req, mem_addr); end
    st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h0000_5008; st_data = 32'h3333_3333;
    step();
    checks++; if (mem_addr !== 32'h0000_5000 || mem_wdata !== 32'h1111_1111 || mem_be !== 4'b1111) begin errors++; $display("FAIL fill_head_stable got %h %h %b exp 00005000 11111111 1111", mem_addr, mem_wdata, mem_be); end
    ack_once();
    st_valid = 1'b0;
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop got %b exp 1", st_ready); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5004 || mem_wdata !== 32'h2222_2222) begin errors++; $display("FAIL fill_next got %b %h %h exp 1 00005004 22222222", mem_req, mem_addr, mem_wdata); end
    ack_once();
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fill_no_third req %b busy %b exp 0 0", mem_req, busy); end
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_no_third_late got %b exp 0", mem_req); end
  endtask

  task automatic test_hazard();
    ld_addr = 32'h0000_3006;
    do_store(2'b10, 32'h0000_3004, 32'hCAFE_F00D);
    checks++; if (ld_hazard !== 1'b1) begin errors++; $display("FAIL hazard_pending got %b exp 1", ld_hazard); end
    ld_addr = 32'h0000_3008;
    #1;
    checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_other_word got %b exp 0", ld_hazard); end
    ld_addr = 32'h0000_3006;
    step();
    checks++; if (ld_hazard !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL hazard_head hz %b req %b exp 1 1", ld_hazard, mem_req); end
    ack_once();
    checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_cleared got %b exp 0", ld_hazard); end
    ld_addr = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] got_addr [8];
    logic [31:0] got_data [8];
    int          got_cyc  [8];
    int i = 0, nw = 0, cyc = 0;
    logic acc, wr;
    mem_ack  = 1'b1;
    st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h0000_6000; st_data = 32'h1000_0000;
    while (nw < 8 && cyc < 60) begin
      acc = st_valid && st_ready;
      wr  = mem_req;
      if (wr) begin
        got_addr[nw] = mem_addr; got_data[nw] = mem_wdata; got_cyc[nw] = cyc;
      end
      step();
      cyc++;
      if (wr) nw++;
      if (acc) i++;
      st_valid = (i < 8);
      st_addr  = 32'h0000_6000 + 32'(i) * 4;
      st_data  = 32'h1000_0000 + 32'(i);
    end
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    checks++; if (nw != 8) begin errors++; $display("FAIL b2b_timeout writes %0d exp 8", nw); end
    for (int k = 0; k < nw; k++) begin
      checks++;
      if (got_addr[k] !== 32'h0000_6000 + 32'(k) * 4 || got_data[k] !== 32'h1000_0000 + 32'(k)) begin
        errors++; $display("FAIL b2b_order[%0d] got %h %h exp %h %h", k, got_addr[k], got_data[k],
                           32'h0000_6000 + 32'(k) * 4, 32'h1000_0000 + 32'(k));
      end
    end
    if (nw == 8) begin
      checks++; if (got_cyc[7] - got_cyc[0] != 7) begin errors++; $display("FAIL b2b_bubbles span %0d exp 7", got_cyc[7] - got_cyc[0]); end
    end
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_drained busy %b req %b exp 0 0", busy, mem_req); end
  endtask

  task automatic test_reset_mid();
    do_store(2'b10, 32'h0000_7000, 32'hDEAD_BEEF);
    do_store(2'b10, 32'h0000_7004, 32'h0BAD_F00D);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre_req got %b exp 1", mem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || mem_be !== 4'b0000) begin errors++; $display("FAIL rstmid_drop req %b busy %b be %b exp 0 0 0000", mem_req, busy, mem_be); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (mem_req !== 1'b0 || st_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d] req %b ready %b busy %b exp 0 1 0", k, mem_req, st_ready, busy); end
    end
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_size = 2'b00; st_addr = '0; st_data = '0;
    mem_ack = 1'b0; ld_addr = '0;
    test_reset();
    test_byte();
    test_half_misalign();
    test_fill();
    test_hazard();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-side data narrowing and write buffer for the MEM stage of the pipelined MIPS CPU; the inverse of the load-path 16→32 sign/zero extension. Accepts sb/sh/sw requests, replicates the narrow register data onto 32-bit memory byte lanes, generates byte enables, and traps misaligned stores. Buffers accepted stores in a small FIFO that drains to data memory over a req/ack handshake. Flags loads that hit a pending store so the pipeline can stall.

## Interface
- DEPTH, 2, store queue entries; must be a power of two and ≥2
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  store request accepted when high with st_valid
- st_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- st_addr  in  32  byte address
- st_data  in  32  register rt value; only the low byte or half is used for sb/sh
- mem_req  out  1  memory write request
- mem_ack  in  1  memory accepted current write
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables, bit i covers mem_wdata[8i+7:8i]
- misalign  out  1  one-cycle pulse: the previous accepted request was misaligned or reserved
- ld_addr  in  32  address of the load currently in MEM
- ld_hazard  out  1  combinational: ld_addr[31:2] matches any valid queue entry
- busy  out  1  queue non-empty or request in flight

## Operation
- Accept: st_valid && st_ready at a rising edge. st_ready = !full; no same-cycle bypass of a pop into a full queue.
- Byte: wdata = {4{st_data[7:0]}}, be = 4'b0001 << st_addr[1:0].
- Half: requires st_addr[0]==0; wdata = {2{st_data[15:0]}}, be = st_addr[1] ? 4'b1100 : 4'b0011.
- Word: requires st_addr[1:0]==0; wdata = st_data, be = 4'b1111.
- Misaligned half or word, or st_size==11: the request is consumed (handshake completes) but is not enqueued. misalign goes high for exactly the next cycle.
- Entry stores {st_addr[31:2], wdata, be}. The queue is FIFO, and write order to memory equals accept order.
- Drain FSM:
  - IDLE: mem_req=0. Go to REQ when the queue is non-empty.
  - REQ: mem_req=1, and mem_addr/wdata/be present the head entry, held stable until mem_ack.
  - On mem_ack, pop the head. Stay in REQ if entries remain, otherwise go to IDLE.
- Enqueue and pop in the same cycle: count is unchanged and both take effect.
- ld_hazard covers all valid entries, including the head currently being presented.

## Timing
- Reset (async, immediate): queue empty, state IDLE, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, misalign=0, busy=0, st_ready=1. Reset mid-handshake drops mem_req and discards all entries.
- Latency: an accept at edge N makes mem_req high after edge N+1 when the queue was empty.
- After mem_ack at edge M, the next entry's outputs are valid and mem_req stays high after edge M; back-to-back writes sustain 1 per cycle with mem_ack tied high.
- mem_ack while mem_req=0 is ignored.
- The pointers are log2(DEPTH) bits wide and wrap naturally. The count is log2(DEPTH)+1 bits wide, so full and empty are unambiguous.
- busy is registered and matches state≠IDLE or count≠0.

## Structure
- Package store_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - FSM state enum {IDLE, REQ}
  - queue entry struct (word address 30 b, data 32 b, be 4 b)
- Sub-module store_lane_align: purely combinational. Maps (size, addr[1:0], data) to (wdata, be, misaligned).
- Top module: FIFO storage, pointers, FSM, and the hazard compare loop.

## Test plan
- sb addr 0x1003 data 0xAABBCC5A → mem_addr 0x1000, wdata 0x5A5A5A5A, be 1000; mem_req high 2 cycles after accept.
- sh addr 0x2002 data 0x1234BEEF → wdata 0xBEEFBEEF, be 1100; sh addr 0x2001 → no write, misalign pulse exactly 1 cycle, busy stays 0.
- Fill the queue (DEPTH stores, mem_ack=0) → st_ready=0 and the head stays stable. Raise mem_ack for one cycle → one pop, st_ready=1, next entry presented.
- Store to 0x3004 is pending; ld_addr 0x3006 → ld_hazard=1. After its mem_ack and queue empty → ld_hazard=0.
- mem_ack held high with a store every cycle, 8 stores → 8 writes in order, no bubbles after the first.
- Assert rst_n=0 while mem_req=1 → mem_req, busy, be drop immediately. After release, no stale write is issued.
